// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for serial_digit_adder.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(ndig), at least one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder_ripple.sv
// digit_ripple_adder: combinational DIGIT-bit ripple chain of full-adder cells.
// CMsb is the carry into the top bit, used for signed-overflow detection.
module digit_ripple_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] Sum,
  output logic             Cout,
  output logic             CMsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i + 1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[DIGIT];
  assign CMsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: WIDTH-bit add/subtract, DIGIT bits per clock, valid/ready on both sides.
// Define SERIAL_DIGIT_ADDER_FLAGS_EN to enable the Overflow/Zero flags (tied to 0 otherwise).
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t r_state, w_next;

  logic [WIDTH-1:0]       r_a, r_b, r_sum;
  logic                   r_carry, r_cout;
  logic [CW-1:0]          r_cnt;
  logic [DIGIT-1:0]       w_dsum;
  logic                   w_dcout, w_dcmsb, w_last;
  logic [WIDTH+DIGIT-1:0] w_cat;

  digit_ripple_adder #(.DIGIT(DIGIT)) u_adder (
    .A    (r_a[DIGIT-1:0]),
    .B    (r_b[DIGIT-1:0]),
    .Cin  (r_carry),
    .Sum  (w_dsum),
    .Cout (w_dcout),
    .CMsb (w_dcmsb)
  );

  assign w_last = (r_cnt == LAST);
  // Upper WIDTH bits of {digit, sum} = sum shifted right with the new digit at the MSB end.
  assign w_cat  = {w_dsum, r_sum};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        InReady = 1'b1;
        if (InValid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        OutValid = 1'b1;
        if (OutReady) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef SERIAL_DIGIT_ADDER_FLAGS_EN
  logic r_ovf;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_DIGIT_ADDER_FLAGS_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (InValid) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{Sub}};
            r_carry <= Sub | Cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_cat[WIDTH+DIGIT-1:DIGIT];
          r_carry <= w_dcout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_dcout;
`ifdef SERIAL_DIGIT_ADDER_FLAGS_EN
            r_ovf  <= w_dcmsb ^ w_dcout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

`ifdef SERIAL_DIGIT_ADDER_FLAGS_EN
  assign Overflow = r_ovf;
  assign Zero     = (r_state == ST_DONE) && (r_sum == '0);
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_dcmsb;
  assign Overflow      = 1'b0;
  assign Zero          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: vector table, scoreboard queue, corner sequences, DIGIT sweep.
module tb_serial_digit_adder;

`ifdef SERIAL_DIGIT_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0, cin = 1'b0;
  logic       in_ready, out_valid, cout, ovf, zero;
  logic [7:0] sum;

  logic       sw_in_valid = 1'b0;
  logic       sw_out_ready = 1'b0;
  logic [2:0] sw_ir, sw_ov, sw_cout, sw_ovf, sw_zero;
  logic [7:0] sw_sum [3];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_dut (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .Sub(sub), .Cin(cin),
    .OutValid(out_valid), .OutReady(out_ready),
    .Sum(sum), .Cout(cout), .Overflow(ovf), .Zero(zero)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .Clk(clk), .Reset(rst), .InValid(sw_in_valid), .InReady(sw_ir[0]),
    .A(a), .B(b), .Sub(sub), .Cin(cin),
    .OutValid(sw_ov[0]), .OutReady(sw_out_ready),
    .Sum(sw_sum[0]), .Cout(sw_cout[0]), .Overflow(sw_ovf[0]), .Zero(sw_zero[0])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .Clk(clk), .Reset(rst), .InValid(sw_in_valid), .InReady(sw_ir[1]),
    .A(a), .B(b), .Sub(sub), .Cin(cin),
    .OutValid(sw_ov[1]), .OutReady(sw_out_ready),
    .Sum(sw_sum[1]), .Cout(sw_cout[1]), .Overflow(sw_ovf[1]), .Zero(sw_zero[1])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .Clk(clk), .Reset(rst), .InValid(sw_in_valid), .InReady(sw_ir[2]),
    .A(a), .B(b), .Sub(sub), .Cin(cin),
    .OutValid(sw_ov[2]), .OutReady(sw_out_ready),
    .Sum(sw_sum[2]), .Cout(sw_cout[2]), .Overflow(sw_ovf[2]), .Zero(sw_zero[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Packed result {cout, ovf, zero, sum}; flags expected 0 when the feature is compiled out.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic ms, input logic mc);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ov;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {8'd0, (ms | mc)};
    ov   = (ma[7] == bb[7]) && (full[7] != ma[7]);
    return {full[8], ov & FLAGS, (full[7:0] == 8'd0) & FLAGS, full[7:0]};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_output", 32'(sum), 32'hFFFF_FFFF);
      else check("sb_result", 32'({cout, ovf, zero, sum}), 32'(sb_q.pop_front()));
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                       input logic tc, input bit push);
    int unsigned n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    if (push) sb_q.push_back(model(ta, tb_, ts, tc));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int unsigned exp_lat);
    int unsigned n;
    for (n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) break;
    end
    check(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff", 32'({in_ready, out_valid}), 32'b10);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sub, cin;
    logic [7:0] sum;
    logic       cout, ovf, zero;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [10:0] exp_r, got_r [3];
    int unsigned lat [3];
    int unsigned viol;
    bit [2:0] seen;
    localparam int unsigned SW_LAT [3] = '{8, 4, 1};

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    // Asynchronous reset mid-cycle, before any clock edge has been seen.
    #2 rst = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_flags", 32'({ovf, zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 6; i++) begin
      exp_r = {vecs[i].cout, vecs[i].ovf & FLAGS, vecs[i].zero & FLAGS, vecs[i].sum};
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0);
      sb_q.push_back(exp_r);
      wait_out("vec_latency", 2);
      drain();
    end

    // Backpressure: outputs hold while inputs churn; no accept on hand-off edge.
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    wait_out("bp_latency", 2);
    for (int unsigned i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = ~in_valid;
      @(posedge clk); #1;
      check("bp_handshake", 32'({in_ready, out_valid}), 32'b01);
      check("bp_stable", 32'({cout, ovf, zero, sum}), 32'({1'b0, 1'b0, 1'b0, 8'h46}));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handoff_idle", 32'({in_ready, out_valid}), 32'b10);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept", 32'(in_ready), 32'd1);

    // Asynchronous reset while holding a result in DONE.
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    wait_out("done_rst_latency", 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("done_rst_state", 32'({in_ready, out_valid, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst = 1'b0;

    // Reset one edge after accept aborts the operation.
    issue(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("run_rst_state", 32'({in_ready, out_valid}), 32'b10);
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) viol++;
    end
    check("run_rst_no_output", 32'(viol), 32'd0);

    // DIGIT sweep against the behavioural model.
    for (int unsigned op = 0; op < 1000; op++) begin
      a = 8'($urandom); b = 8'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      if (op % 16 == 0) b = sub ? a : 8'(-a);
      exp_r = model(a, b, sub, cin);
      check("sweep_ready", 32'(sw_ir), 32'b111);
      sw_in_valid = 1'b1;
      @(posedge clk); #1;
      sw_in_valid = 1'b0;
      seen = '0;
      for (int unsigned g = 0; g < 3; g++) begin
        lat[g] = 0; got_r[g] = '0;
      end
      for (int unsigned n = 1; n <= 12 && seen != 3'b111; n++) begin
        @(posedge clk); #1;
        for (int unsigned g = 0; g < 3; g++) begin
          if (!seen[g] && sw_ov[g] === 1'b1) begin
            seen[g]  = 1'b1;
            lat[g]   = n;
            got_r[g] = {sw_cout[g], sw_ovf[g], sw_zero[g], sw_sum[g]};
          end
        end
      end
      for (int unsigned g = 0; g < 3; g++)
        check("sweep_result", {17'd0, 4'(lat[g]), got_r[g]}, {17'd0, 4'(SW_LAT[g]), exp_r});
      sw_out_ready = 1'b1;
      @(posedge clk); #1;
      sw_out_ready = 1'b0;
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
